// File: rtl/global_params.sv
// Shared NoC definitions: link directions, default widths, the flit record
// carried from the injector FIFO to the router link, and the delta helper.
package global_params;

  localparam int COORD_W = 4;
  localparam int DATA_W  = 32;

  typedef enum logic [2:0] {
    DIR_LOCAL,
    DIR_NORTH,
    DIR_EAST,
    DIR_SOUTH,
    DIR_WEST
  } direction_e;

  typedef struct packed {
    logic [COORD_W:0]   s_delta_x;
    logic [COORD_W:0]   s_delta_y;
    logic [COORD_W-1:0] dest_x;
    logic [COORD_W-1:0] dest_y;
    logic [DATA_W-1:0]  data;
  } noc_flit_t;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } inj_state_e;

  // Both operands are zero-extended by one bit, so the result is a correct
  // two's-complement difference for any pair of in-range coordinates.
  function automatic logic [COORD_W:0] coord_delta(input logic [COORD_W-1:0] dest,
                                                   input logic [COORD_W-1:0] src);
    return {1'b0, dest} - {1'b0, src};
  endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Synchronous FIFO with an extra wrap bit on each pointer to tell full from
// empty. Push when full and pop when empty are ignored.
module noc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W:0]   wr_q, wr_d;
  logic [PTR_W:0]   rd_q, rd_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (wr_q[PTR_W] != rd_q[PTR_W]) &&
                   (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_q[PTR_W-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + (PTR_W+1)'(1);
    if (do_pop)  rd_d = rd_q + (PTR_W+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // NOTE: storage is not reset; only the pointers are, so no stale entry can
  // ever be read and the array maps onto plain RAM/flops without reset logic.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[PTR_W-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/noc_injector.sv
// Transmit-side network interface: validates local requests, converts the
// destination into router deltas, queues them and drives one valid/ready link.
module noc_injector #(
  parameter int MESH_SIDE   = 4,
  parameter int COORD_W     = 4,
  parameter int DATA_W      = 32,
  parameter int SRC_X       = 0,
  parameter int SRC_Y       = 0,
  parameter int FIFO_DEPTH  = 4,
  parameter int STALL_LIMIT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [COORD_W-1:0] req_dest_x,
  input  logic [COORD_W-1:0] req_dest_y,
  input  logic [DATA_W-1:0]  req_data,
  output logic               link_valid,
  input  logic               link_ready,
  output logic [COORD_W:0]   link_s_delta_x,
  output logic [COORD_W:0]   link_s_delta_y,
  output logic [COORD_W-1:0] link_dest_x,
  output logic [COORD_W-1:0] link_dest_y,
  output logic [DATA_W-1:0]  link_data,
  output logic               err_pulse,
  output logic               stall_alarm,
  output logic [15:0]        sent_count,
  output logic [15:0]        drop_count
);

  import global_params::noc_flit_t;
  import global_params::inj_state_e;
  import global_params::ST_IDLE;
  import global_params::ST_SEND;
  import global_params::coord_delta;

  localparam int STALL_W = $clog2(STALL_LIMIT + 1);
  localparam logic [COORD_W-1:0] SRC_X_C = COORD_W'(SRC_X);
  localparam logic [COORD_W-1:0] SRC_Y_C = COORD_W'(SRC_Y);

  inj_state_e       state_q, state_d;
  noc_flit_t        flit_q, flit_d;
  noc_flit_t        new_flit;
  noc_flit_t        head_flit;
  logic             fifo_full, fifo_empty;
  logic             fifo_pop;
  logic             live_q;
  logic             req_fire, req_bad;
  logic             link_fire;
  logic             err_q;
  logic [15:0]      sent_q, sent_d;
  logic [15:0]      drop_q, drop_d;
  logic [STALL_W-1:0] stall_q, stall_d;

  // live_q keeps req_ready low during reset and for the release edge itself.
  assign req_ready = live_q && !fifo_full;
  assign req_fire  = req_valid && req_ready;
  assign req_bad   = (int'(req_dest_x) >= MESH_SIDE) ||
                     (int'(req_dest_y) >= MESH_SIDE) ||
                     ((req_dest_x == SRC_X_C) && (req_dest_y == SRC_Y_C));

  always_comb begin
    new_flit.s_delta_x = coord_delta(req_dest_x, SRC_X_C);
    new_flit.s_delta_y = coord_delta(req_dest_y, SRC_Y_C);
    new_flit.dest_x    = req_dest_x;
    new_flit.dest_y    = req_dest_y;
    new_flit.data      = req_data;
  end

  noc_sync_fifo #(
    .WIDTH ($bits(noc_flit_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (req_fire && !req_bad),
    .wdata_i (new_flit),
    .pop_i   (fifo_pop),
    .rdata_o (head_flit),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign link_valid = (state_q == ST_SEND);
  assign link_fire  = link_valid && link_ready;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    flit_d   = flit_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          flit_d   = head_flit;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        // The held flit only changes on a completed transfer.
        if (link_ready) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            flit_d   = head_flit;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sent_d  = link_fire ? sent_q + 16'd1 : sent_q;
    drop_d  = (req_fire && req_bad) ? drop_q + 16'd1 : drop_q;
    stall_d = stall_q;
    if (link_fire)
      stall_d = '0;
    else if (link_valid && (stall_q != STALL_W'(STALL_LIMIT)))
      stall_d = stall_q + STALL_W'(1);
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values computed by the combinational blocks above.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      flit_q  <= '0;
      live_q  <= 1'b0;
      err_q   <= 1'b0;
      sent_q  <= '0;
      drop_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      flit_q  <= flit_d;
      live_q  <= 1'b1;
      err_q   <= req_fire && req_bad;
      sent_q  <= sent_d;
      drop_q  <= drop_d;
      stall_q <= stall_d;
    end
  end

  assign link_s_delta_x = flit_q.s_delta_x;
  assign link_s_delta_y = flit_q.s_delta_y;
  assign link_dest_x    = flit_q.dest_x;
  assign link_dest_y    = flit_q.dest_y;
  assign link_data      = flit_q.data;
  assign err_pulse      = err_q;
  assign stall_alarm    = (stall_q == STALL_W'(STALL_LIMIT));
  assign sent_count     = sent_q;
  assign drop_count     = drop_q;

endmodule

// File: tb/tb_noc_injector.sv
// Directed bench for noc_injector at SRC=(1,1) on a 4x4 mesh: a vector table
// for delta/reject behaviour plus sequences for backpressure, stall, reset, wrap.
module tb_noc_injector;

  localparam int CW = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [CW-1:0] req_dest_x, req_dest_y;
  logic [DW-1:0] req_data;
  logic          link_valid;
  logic          link_ready;
  logic [CW:0]   link_s_delta_x, link_s_delta_y;
  logic [CW-1:0] link_dest_x, link_dest_y;
  logic [DW-1:0] link_data;
  logic          err_pulse;
  logic          stall_alarm;
  logic [15:0]   sent_count, drop_count;

  int checks = 0;
  int errors = 0;

  noc_injector #(
    .MESH_SIDE   (4),
    .COORD_W     (CW),
    .DATA_W      (DW),
    .SRC_X       (1),
    .SRC_Y       (1),
    .FIFO_DEPTH  (4),
    .STALL_LIMIT (64)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_dest_x     (req_dest_x),
    .req_dest_y     (req_dest_y),
    .req_data       (req_data),
    .link_valid     (link_valid),
    .link_ready     (link_ready),
    .link_s_delta_x (link_s_delta_x),
    .link_s_delta_y (link_s_delta_y),
    .link_dest_x    (link_dest_x),
    .link_dest_y    (link_dest_y),
    .link_data      (link_data),
    .err_pulse      (err_pulse),
    .stall_alarm    (stall_alarm),
    .sent_count     (sent_count),
    .drop_count     (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_req(input logic [CW-1:0] dx, input logic [CW-1:0] dy,
                           input logic [DW-1:0] data);
    req_valid  = 1'b1;
    req_dest_x = dx;
    req_dest_y = dy;
    req_data   = data;
  endtask

  typedef struct {
    logic [CW-1:0] dx;
    logic [CW-1:0] dy;
    logic [DW-1:0] data;
    logic          err;
    logic [CW:0]   sx;
    logic [CW:0]   sy;
  } vec_t;

  vec_t vecs[9];
  logic [DW-1:0] bp_data [5];
  logic [CW-1:0] bp_dx   [5];
  logic [CW-1:0] bp_dy   [5];

  initial begin
    int exp_sent;
    int exp_drop;
    int stale;
    int reqs;
    int xfers;

    // Hand-computed vectors for SRC=(1,1); deltas are 5-bit two's complement.
    vecs[0] = '{dx: 4'd3, dy: 4'd0,  data: 32'h1111_0001, err: 1'b0, sx: 5'h02, sy: 5'h1F};
    vecs[1] = '{dx: 4'd0, dy: 4'd0,  data: 32'h1111_0002, err: 1'b0, sx: 5'h1F, sy: 5'h1F};
    vecs[2] = '{dx: 4'd0, dy: 4'd3,  data: 32'h1111_0003, err: 1'b0, sx: 5'h1F, sy: 5'h02};
    vecs[3] = '{dx: 4'd3, dy: 4'd3,  data: 32'h1111_0004, err: 1'b0, sx: 5'h02, sy: 5'h02};
    vecs[4] = '{dx: 4'd1, dy: 4'd2,  data: 32'h1111_0005, err: 1'b0, sx: 5'h00, sy: 5'h01};
    vecs[5] = '{dx: 4'd4, dy: 4'd0,  data: 32'h2222_0001, err: 1'b1, sx: 5'h00, sy: 5'h00};
    vecs[6] = '{dx: 4'd1, dy: 4'd1,  data: 32'h2222_0002, err: 1'b1, sx: 5'h00, sy: 5'h00};
    vecs[7] = '{dx: 4'd0, dy: 4'd15, data: 32'h2222_0003, err: 1'b1, sx: 5'h00, sy: 5'h00};
    vecs[8] = '{dx: 4'd2, dy: 4'd1,  data: 32'h1111_0006, err: 1'b0, sx: 5'h01, sy: 5'h00};

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_dest_x = '0;
    req_dest_y = '0;
    req_data   = '0;
    link_ready = 1'b0;
    repeat (3) tick();

    check("rst_link_valid", link_valid, 1'b0);
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_err_pulse", err_pulse, 1'b0);
    check("rst_stall", stall_alarm, 1'b0);
    check("rst_sent", sent_count, 16'd0);
    check("rst_drop", drop_count, 16'd0);
    check("rst_link_data", link_data, 32'd0);

    rst = 1'b0;
    tick();
    check("post_rst_ready", req_ready, 1'b1);

    // Minimum latency: accepted at the first edge, on the link two cycles later.
    link_ready = 1'b1;
    drive_req(4'd3, 4'd0, 32'hA5A5_A5A5);
    tick();
    req_valid = 1'b0;
    check("lat_valid_c1", link_valid, 1'b0);
    tick();
    check("lat_valid_c2", link_valid, 1'b1);
    check("lat_sx", link_s_delta_x, 5'h02);
    check("lat_sy", link_s_delta_y, 5'h1F);
    check("lat_dx", link_dest_x, 4'd3);
    check("lat_dy", link_dest_y, 4'd0);
    check("lat_data", link_data, 32'hA5A5_A5A5);
    tick();
    check("lat_sent", sent_count, 16'd1);
    check("lat_idle", link_valid, 1'b0);

    exp_sent = 1;
    exp_drop = 0;
    for (int i = 0; i < 9; i++) begin
      drive_req(vecs[i].dx, vecs[i].dy, vecs[i].data);
      tick();
      req_valid = 1'b0;
      check($sformatf("vec%0d_err", i), err_pulse, vecs[i].err);
      check($sformatf("vec%0d_early", i), link_valid, 1'b0);
      tick();
      check($sformatf("vec%0d_valid", i), link_valid, !vecs[i].err);
      if (!vecs[i].err) begin
        check($sformatf("vec%0d_sx", i), link_s_delta_x, vecs[i].sx);
        check($sformatf("vec%0d_sy", i), link_s_delta_y, vecs[i].sy);
        check($sformatf("vec%0d_dest", i), {link_dest_x, link_dest_y}, {vecs[i].dx, vecs[i].dy});
        check($sformatf("vec%0d_data", i), link_data, vecs[i].data);
        exp_sent++;
      end else begin
        exp_drop++;
      end
      tick();
      check($sformatf("vec%0d_sent", i), sent_count, 16'(exp_sent));
      check($sformatf("vec%0d_drop", i), drop_count, 16'(exp_drop));
    end

    // Backpressure: one flit held on the link plus four queued fills everything.
    link_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bp_dx[i]   = (i < 4) ? 4'd3 : 4'd2;
      bp_dy[i]   = (i < 4) ? 4'(i) : 4'd0;
      bp_data[i] = 32'hB000_0000 + 32'(i);
      check($sformatf("bp_ready%0d", i), req_ready, 1'b1);
      drive_req(bp_dx[i], bp_dy[i], bp_data[i]);
      tick();
    end
    drive_req(4'd3, 4'd3, 32'hDEAD_BEEF);
    check("bp_full", req_ready, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp_hold_valid%0d", k), link_valid, 1'b1);
      check($sformatf("bp_hold_data%0d", k), link_data, bp_data[0]);
      check($sformatf("bp_hold_dest%0d", k), {link_dest_x, link_dest_y}, {bp_dx[0], bp_dy[0]});
      check($sformatf("bp_hold_sx%0d", k), link_s_delta_x, 5'h02);
      tick();
    end
    req_valid = 1'b0;
    check("bp_still_full", req_ready, 1'b0);
    link_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_out_valid%0d", i), link_valid, 1'b1);
      check($sformatf("bp_out_data%0d", i), link_data, bp_data[i]);
      check($sformatf("bp_out_dest%0d", i), {link_dest_x, link_dest_y}, {bp_dx[i], bp_dy[i]});
      tick();
    end
    exp_sent += 5;
    check("bp_drained", link_valid, 1'b0);
    check("bp_sent", sent_count, 16'(exp_sent));

    // Stall alarm: saturating count of blocked cycles.
    link_ready = 1'b0;
    drive_req(4'd2, 4'd2, 32'hC0C0_C0C0);
    tick();
    req_valid = 1'b0;
    tick();
    check("stall_start_valid", link_valid, 1'b1);
    check("stall_start_alarm", stall_alarm, 1'b0);
    for (int k = 1; k <= 70; k++) begin
      tick();
      if (k == 63) check("stall_63", stall_alarm, 1'b0);
      if (k == 64) check("stall_64", stall_alarm, 1'b1);
      if (k == 70) check("stall_70", stall_alarm, 1'b1);
    end
    check("stall_held_data", link_data, 32'hC0C0_C0C0);
    link_ready = 1'b1;
    check("stall_xfer_cycle", stall_alarm, 1'b1);
    tick();
    check("stall_cleared", stall_alarm, 1'b0);
    check("stall_done_valid", link_valid, 1'b0);
    exp_sent++;
    check("stall_sent", sent_count, 16'(exp_sent));

    // Reset with one flit stalled and three queued: nothing survives.
    link_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_req(4'd3, 4'(i), 32'hE000_0000 + 32'(i));
      tick();
    end
    req_valid = 1'b0;
    check("mid_rst_pre_valid", link_valid, 1'b1);
    rst = 1'b1;
    tick();
    check("mid_rst_valid", link_valid, 1'b0);
    check("mid_rst_sent", sent_count, 16'd0);
    check("mid_rst_drop", drop_count, 16'd0);
    check("mid_rst_ready", req_ready, 1'b0);
    check("mid_rst_data", link_data, 32'd0);
    rst = 1'b0;
    link_ready = 1'b1;
    stale = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (link_valid) stale++;
    end
    check("mid_rst_stale", 32'(stale), 32'd0);
    check("mid_rst_ready_back", req_ready, 1'b1);
    check("mid_rst_sent_after", sent_count, 16'd0);

    // 65537 packets of continuous traffic wrap sent_count to 1.
    reqs  = 0;
    xfers = 0;
    for (int cyc = 0; cyc < 70000 && xfers < 65537; cyc++) begin
      req_valid  = (reqs < 65537);
      req_dest_x = 4'd3;
      req_dest_y = 4'd3;
      req_data   = 32'(reqs);
      if (req_valid && req_ready) reqs++;
      if (link_valid && link_ready) xfers++;
      tick();
    end
    req_valid = 1'b0;
    check("wrap_xfers", 32'(xfers), 32'd65537);
    check("wrap_sent", sent_count, 16'd1);
    tick();
    check("wrap_idle", link_valid, 1'b0);
    check("wrap_drop", drop_count, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/noc_injector.md
Name: noc_injector

Overview:
- Transmit-side network interface that takes local packet requests and drives one mesh router input link using the valid/ready link protocol.
- Converts each absolute destination into the signed deltas (s_delta_x, s_delta_y) that routers use. Buffers requests in a small FIFO and holds each packet stable on the link until it is accepted.
- One instance sits at every local or edge injection point of the mesh. It also reports rejected requests and stalled links.

Parameters:
- MESH_SIDE, 4, mesh dimension; legal coordinates are 0..MESH_SIDE-1
- COORD_W, 4, width of dest_x/dest_y; must satisfy 2**COORD_W >= MESH_SIDE
- DATA_W, 32, payload width
- SRC_X, 0, X coordinate of the attached router
- SRC_Y, 0, Y coordinate of the attached router
- FIFO_DEPTH, 4, request FIFO entries; power of two, at least 2
- STALL_LIMIT, 64, consecutive blocked cycles before stall_alarm asserts

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  local request valid
- req_ready  out  1  FIFO can accept a request
- req_dest_x  in  COORD_W  destination X
- req_dest_y  in  COORD_W  destination Y
- req_data  in  DATA_W  payload
- link_valid  out  1  packet on link valid
- link_ready  in  1  router input accepts
- link_s_delta_x  out  COORD_W+1  signed dest_x-SRC_X
- link_s_delta_y  out  COORD_W+1  signed dest_y-SRC_Y
- link_dest_x  out  COORD_W  destination X
- link_dest_y  out  COORD_W  destination Y
- link_data  out  DATA_W  payload
- err_pulse  out  1  one-cycle pulse on a rejected request
- stall_alarm  out  1  link blocked for at least STALL_LIMIT cycles
- sent_count  out  16  packets accepted by link, wraps
- drop_count  out  16  requests rejected, wraps

Behaviour:
- Reset values: all outputs 0, FIFO empty, both counters 0, FSM in IDLE. req_ready rises in the first cycle after rst deasserts. Reset mid-transfer discards the FIFO contents and the held packet with no partial delivery.
- Request transfer: occurs when req_valid && req_ready.
- Request rejection: a request is rejected when dest_x >= MESH_SIDE, or dest_y >= MESH_SIDE, or (dest_x, dest_y) == (SRC_X, SRC_Y).
  - A rejected request is still consumed (the handshake completes) but is not enqueued.
  - err_pulse=1 in the next cycle; drop_count increments.
- req_ready = !fifo_full. A request arriving in the same cycle as a dequeue from a full FIFO is NOT accepted (no fall-through on full).
- Delta computation: deltas are computed at enqueue time, zero-extended operands, result is COORD_W+1 two's complement, and stored in the FIFO.
  - Example: SRC=(2,1), dest=(0,3) gives s_delta_x = -2, s_delta_y = +2.
- FSM IDLE:
  - If the FIFO is non-empty, pop the head into the output register, set link_valid=1 next cycle, and go to SEND.
  - Minimum latency from request accept to link_valid is 2 cycles.
- FSM SEND:
  - Output register fields are held stable while link_valid && !link_ready. Changing any link field during a stall is a protocol violation.
  - On link_valid && link_ready, sent_count increments. If the FIFO is non-empty, the next entry is popped in the same cycle, so back-to-back packets go out at one per cycle with link_valid held at 1. Otherwise link_valid=0 and the FSM returns to IDLE.
- Stall counter:
  - Counts cycles with link_valid && !link_ready and saturates at STALL_LIMIT.
  - stall_alarm=1 while counter == STALL_LIMIT.
  - The counter and the alarm clear in the cycle after the link transfer completes.
- Simultaneous events: enqueue and dequeue in the same cycle leave the FIFO occupancy unchanged. The FIFO pointers wrap modulo FIFO_DEPTH.
- Counters: both wrap from 0xFFFF to 0 with no flag.

Decomposition:
- The shared global_params package holds:
  - direction enum (already present)
  - COORD_W/DATA_W constants
  - a packed struct noc_flit_t {s_delta_x, s_delta_y, dest_x, dest_y, data}
- One sub-module, noc_sync_fifo: parameterized over width and depth, synchronous, active-high reset, full/empty flags. It stores noc_flit_t.

Test Plan:
- Reset, then SRC=(1,1); request dest=(3,0), data=0xA5A5A5A5, link_ready=1 -> link_valid in cycle +2 with deltas (+2,-1) and the same data; sent_count=1.
- Hold link_ready=0 and issue 5 requests (FIFO_DEPTH=4) -> req_ready drops after 4 accepts plus the 1 held in the output register; link fields stable throughout; raise link_ready -> 5 packets in consecutive cycles, in order.
- dest=(4,0) with MESH_SIDE=4, and dest=(SRC_X,SRC_Y) -> two err_pulses, drop_count=2, no link_valid.
- link_ready=0 for 70 cycles with a pending packet -> stall_alarm rises at blocked cycle 64 and clears one cycle after the transfer.
- Assert rst while 3 packets are queued and one is stalled -> next cycle link_valid=0, counters 0, and no stale packet is emitted after release.
- Continuous traffic of 65537 packets -> sent_count wraps to 1.
